sha256_round_engine: RTL

SHA256_ROUND_ENGINE -- requirements
Module: sha256_round_engine

---
 rtl/sha256_round_engine.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: UNROLL chained rounds per clock with a sliding
// 16-word message schedule and an optional feed-forward of the chaining value.
module sha256_round_engine #(
  parameter int UNROLL       = 1,
  parameter int FEED_FORWARD = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] chain_in,
  input  logic [511:0] block_in,
  output logic         ready,
  output logic         valid_out,
  output logic [255:0] digest_out
);

  // state | meaning
  // IDLE  | waiting for start; ready high
  // RUN   | UNROLL rounds per cycle until 64 rounds are done
  // DONE  | load digest_out, pulse valid_out, return to IDLE
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sha256_round_engine: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [0:63][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sml_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sml_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state;
  logic [6:0]  round_cnt;
  logic [31:0] wv [8];        // working variables A..H
  logic [31:0] chain [8];
  logic [31:0] win [16];      // win[0] holds W[round_cnt]

  logic [31:0] wv_nxt [8];
  logic [31:0] win_nxt [16];
  logic [31:0] ext [24];
  logic [31:0] rd_t1;
  logic [31:0] rd_t2;

  assign ready = (state == IDLE);

  // ext[] is the window extended by the UNROLL new schedule words
  always_comb begin
    rd_t1 = '0;
    rd_t2 = '0;
    for (int i = 0; i < 8; i++) wv_nxt[i] = wv[i];
    for (int i = 0; i < 16; i++) ext[i] = win[i];
    for (int i = 16; i < 24; i++) ext[i] = '0;
    for (int k = 0; k < UNROLL; k++)
      ext[16+k] = sml_s1(ext[14+k]) + ext[9+k] + sml_s0(ext[1+k]) + ext[k];
    for (int j = 0; j < UNROLL; j++) begin
      rd_t1 = wv_nxt[7] + big_s1(wv_nxt[4])
            + ((wv_nxt[4] & wv_nxt[5]) ^ (~wv_nxt[4] & wv_nxt[6]))
            + K_TABLE[round_cnt[5:0] + 6'(j)] + ext[j];
      rd_t2 = big_s0(wv_nxt[0])
            + ((wv_nxt[0] & wv_nxt[1]) ^ (wv_nxt[0] & wv_nxt[2]) ^ (wv_nxt[1] & wv_nxt[2]));
      for (int i = 7; i > 0; i--) wv_nxt[i] = wv_nxt[i-1];
      wv_nxt[4] = wv_nxt[4] + rd_t1;
      wv_nxt[0] = rd_t1 + rd_t2;
    end
    for (int i = 0; i < 16; i++) win_nxt[i] = ext[i+UNROLL];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      round_cnt  <= '0;
      valid_out  <= 1'b0;
      digest_out <= '0;
      for (int i = 0; i < 8; i++) begin
        wv[i]    <= '0;
        chain[i] <= '0;
      end
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 8; i++) begin
              wv[i]    <= chain_in[255-32*i -: 32];
              chain[i] <= chain_in[255-32*i -: 32];
            end
            for (int i = 0; i < 16; i++) win[i] <= block_in[511-32*i -: 32];
            round_cnt <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < 8; i++) wv[i] <= wv_nxt[i];
          for (int i = 0; i < 16; i++) win[i] <= win_nxt[i];
          round_cnt <= round_cnt + 7'(UNROLL);
          if (round_cnt + 7'(UNROLL) == 7'd64) state <= DONE;
        end
        DONE: begin
          for (int i = 0; i < 8; i++)
            digest_out[255-32*i -: 32] <= (FEED_FORWARD != 0) ? chain[i] + wv[i] : wv[i];
          valid_out <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
